// File: rtl/mc_controller_hs.sv
// Multi-cycle control unit: ARM condition codes, mem request/ready handshake, ALU op decode.
// Optional memory wait timeout compiled in with MC_CTRL_TIMEOUT_EN.
module mc_controller_hs #(
  parameter int IW       = 32,
  parameter int FUNC_W   = 3,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     inst,
  input  logic [FUNC_W-1:0] func,
  input  logic              z,
  input  logic              c,
  input  logic              n,
  input  logic              v,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_write,
  output logic              lord,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pcsrc,
  output logic              link,
  output logic              data_to_mem,
  output logic              reg_write,
  output logic              alusrca,
  output logic              ldz,
  output logic              ldc,
  output logic              ldn,
  output logic              ldv,
  output logic [1:0]        alusrcb,
  output logic [1:0]        reg_data,
  output logic [FUNC_W-1:0] alu_operation,
  output logic              illegal,
  output logic              fault
);

  localparam logic [3:0] S_IDLE = 4'd0,  S_IF   = 4'd1,  S_ID    = 4'd2,  S_EX = 4'd3;
  localparam logic [3:0] S_WB   = 4'd4,  S_BR   = 4'd5,  S_LNK   = 4'd6,  S_ADDR = 4'd7;
  localparam logic [3:0] S_ST   = 4'd8,  S_LD   = 4'd9,  S_LDWB  = 4'd10, S_FAULT = 4'd11;

  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNC = 2'd2;

  if (IW < 32 || FUNC_W < 3 || MAX_WAIT > (2**WAIT_W) - 1) begin : g_bad_cfg
    $error("mc_controller_hs: illegal parameter combination");
  end

  logic [3:0] state_reg, state_next;
  logic [1:0] alu_sel;

  logic [3:0] cond;
  logic [2:0] opc;
  logic       l_bit, i_bit, s_bit;
  logic       unused_inst_bits;

  assign cond  = inst[IW-1:IW-4];
  assign opc   = inst[IW-5:IW-7];
  assign l_bit = inst[IW-8];
  assign i_bit = inst[IW-9];
  assign s_bit = inst[IW-12];
  assign unused_inst_bits = ^{inst[IW-10:IW-11], inst[IW-13:0]};

  logic cond_pass, opc_legal, fn_wb, fn_full_flags, timeout;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'd0:  cond_pass = z;
      4'd1:  cond_pass = !z;
      4'd2:  cond_pass = c;
      4'd3:  cond_pass = !c;
      4'd4:  cond_pass = n;
      4'd5:  cond_pass = !n;
      4'd6:  cond_pass = v;
      4'd7:  cond_pass = !v;
      4'd8:  cond_pass = c && !z;
      4'd9:  cond_pass = !c || z;
      4'd10: cond_pass = (n == v);
      4'd11: cond_pass = (n != v);
      4'd12: cond_pass = !z && (n == v);
      4'd13: cond_pass = z || (n != v);
      4'd14: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign opc_legal     = (opc == 3'b000) || (opc == 3'b010) || (opc == 3'b101);
  assign fn_wb         = !((func == FUNC_W'(5)) || (func == FUNC_W'(6)));
  assign fn_full_flags = (func == FUNC_W'(0)) || (func == FUNC_W'(1)) ||
                         (func == FUNC_W'(2)) || (func == FUNC_W'(6));

`ifdef MC_CTRL_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_reg;
  logic              in_wait;

  assign in_wait = (state_reg == S_IF) || (state_reg == S_ST) || (state_reg == S_LD);
  assign timeout = in_wait && !mem_ready && (wait_reg == WAIT_W'(MAX_WAIT));

  // Counter is zero whenever an access starts: any ready cycle or non-wait state clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       wait_reg <= '0;
    else if (in_wait && !mem_ready) wait_reg <= wait_reg + 1'b1;
    else                            wait_reg <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: state_next = S_IF;
      S_IF:   if (mem_ready) state_next = S_ID;
              else if (timeout) state_next = S_FAULT;
      S_ID: begin
        if (!opc_legal || !cond_pass) state_next = S_IF;
        else if (opc == 3'b000)      state_next = S_EX;
        else if (opc == 3'b010)      state_next = S_ADDR;
        else                         state_next = S_BR;
      end
      S_EX:   state_next = fn_wb ? S_WB : S_IF;
      S_WB:   state_next = S_IF;
      S_BR:   state_next = l_bit ? S_LNK : S_IF;
      S_LNK:  state_next = S_IF;
      S_ADDR: state_next = s_bit ? S_ST : S_LD;
      S_ST:   if (mem_ready) state_next = S_IF;
              else if (timeout) state_next = S_FAULT;
      S_LD:   if (mem_ready) state_next = S_LDWB;
              else if (timeout) state_next = S_FAULT;
      S_LDWB: state_next = S_IF;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0; mem_write = 1'b0; lord = 1'b0; ir_write = 1'b0;
    pc_write = 1'b0; pcsrc = 1'b0; link = 1'b0; data_to_mem = 1'b0;
    reg_write = 1'b0; alusrca = 1'b0;
    ldz = 1'b0; ldc = 1'b0; ldn = 1'b0; ldv = 1'b0;
    alusrcb = 2'b00; reg_data = 2'b00; alu_sel = ALU_ADD;
    illegal = 1'b0; fault = 1'b0;
    case (state_reg)
      S_IF: begin
        mem_req = 1'b1; alusrcb = 2'b01;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      S_ID: begin
        alusrcb = 2'b10; illegal = !opc_legal;
      end
      S_EX: begin
        alusrca = 1'b1; alusrcb = i_bit ? 2'b10 : 2'b00; alu_sel = ALU_FUNC;
        ldz = 1'b1; ldn = 1'b1; ldc = fn_full_flags; ldv = fn_full_flags;
      end
      S_WB:   begin reg_write = 1'b1; reg_data = 2'b00; end
      S_BR:   begin pc_write = 1'b1; pcsrc = 1'b1; end
      S_LNK:  begin link = 1'b1; reg_data = 2'b10; reg_write = 1'b1; end
      S_ADDR: begin data_to_mem = 1'b1; alusrca = 1'b1; alusrcb = 2'b10; end
      S_ST:   begin mem_req = 1'b1; mem_write = 1'b1; lord = 1'b1; end
      S_LD:   begin mem_req = 1'b1; lord = 1'b1; end
      S_LDWB: begin reg_write = 1'b1; reg_data = 2'b01; end
`ifdef MC_CTRL_TIMEOUT_EN
      S_FAULT: fault = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (alu_sel)
      ALU_FUNC: alu_operation = func;
      ALU_SUB:  alu_operation = FUNC_W'(1);
      default:  alu_operation = '0;
    endcase
  end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Randomized instruction-level bench for mc_controller_hs; each instruction expands
// into its expected per-cycle strobe sequence and is compared cycle by cycle.
module tb_mc_controller_hs;
  localparam int IW = 32;
  localparam int FW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [IW-1:0] inst;
  logic [FW-1:0] func;
  logic z, c, n, v, mem_ready;
  logic mem_req, mem_write, lord, ir_write, pc_write, pcsrc, link, data_to_mem, reg_write, alusrca;
  logic ldz, ldc, ldn, ldv, illegal, fault;
  logic [1:0] alusrcb, reg_data;
  logic [FW-1:0] alu_operation;

  always #5 clk = ~clk;

  mc_controller_hs dut (
    .clk(clk), .rst(rst), .inst(inst), .func(func),
    .z(z), .c(c), .n(n), .v(v), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .lord(lord), .ir_write(ir_write),
    .pc_write(pc_write), .pcsrc(pcsrc), .link(link), .data_to_mem(data_to_mem),
    .reg_write(reg_write), .alusrca(alusrca),
    .ldz(ldz), .ldc(ldc), .ldn(ldn), .ldv(ldv),
    .alusrcb(alusrcb), .reg_data(reg_data), .alu_operation(alu_operation),
    .illegal(illegal), .fault(fault)
  );

  typedef struct packed {
    logic mem_req, mem_write, lord, ir_write, pc_write, pcsrc, link, data_to_mem, reg_write, alusrca;
    logic ldz, ldc, ldn, ldv;
    logic [1:0] alusrcb, reg_data;
    logic [2:0] alu_op;
    logic illegal, fault;
  } outs_t;

  typedef struct {
    outs_t e;
    logic  rdy;
  } cyc_t;

  cyc_t  q[$];
  int    tests = 0;
  int    fails = 0;
  string cur_tag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic outs_t obs();
    outs_t o;
    o.mem_req = mem_req; o.mem_write = mem_write; o.lord = lord; o.ir_write = ir_write;
    o.pc_write = pc_write; o.pcsrc = pcsrc; o.link = link; o.data_to_mem = data_to_mem;
    o.reg_write = reg_write; o.alusrca = alusrca;
    o.ldz = ldz; o.ldc = ldc; o.ldn = ldn; o.ldv = ldv;
    o.alusrcb = alusrcb; o.reg_data = reg_data; o.alu_op = alu_operation;
    o.illegal = illegal; o.fault = fault;
    return o;
  endfunction

  // ARM condition semantics
  function automatic bit cond_ok(input logic [3:0] cc);
    case (cc)
      0: return z == 1;             1: return z == 0;
      2: return c == 1;             3: return c == 0;
      4: return n == 1;             5: return n == 0;
      6: return v == 1;             7: return v == 0;
      8: return c && !z;            9: return !c || z;
      10: return n == v;            11: return n != v;
      12: return !z && n == v;      13: return z || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic add(input outs_t e, input logic r);
    cyc_t t;
    t.e = e; t.rdy = r;
    q.push_back(t);
  endtask

  task automatic mem_phase(input outs_t base, input int w, input bit fetch);
    outs_t e;
    for (int k = 0; k <= w; k++) begin
      e = base;
      if (fetch) begin e.ir_write = (k == w); e.pc_write = (k == w); end
      add(e, k == w);
    end
  endtask

  task automatic gen(input logic [3:0] cc, input logic [2:0] opc, input bit lb, input bit ib,
                     input bit sb, input logic [2:0] f, input int wif, input int wmem);
    outs_t e;
    bit    ill, full;
    e = '0; e.mem_req = 1; e.alusrcb = 2'b01;
    mem_phase(e, wif, 1);
    ill = !(opc == 3'd0 || opc == 3'd2 || opc == 3'd5);
    e = '0; e.alusrcb = 2'b10; e.illegal = ill;
    add(e, 1'($urandom));
    if (ill || !cond_ok(cc)) return;
    if (opc == 3'd0) begin
      full = (f == 0 || f == 1 || f == 2 || f == 6);
      e = '0; e.alusrca = 1; e.alusrcb = ib ? 2'b10 : 2'b00; e.alu_op = f;
      e.ldz = 1; e.ldn = 1; e.ldc = full; e.ldv = full;
      add(e, 1'($urandom));
      if (!(f == 5 || f == 6)) begin e = '0; e.reg_write = 1; add(e, 1'($urandom)); end
    end else if (opc == 3'd5) begin
      e = '0; e.pc_write = 1; e.pcsrc = 1; add(e, 1'($urandom));
      if (lb) begin e = '0; e.link = 1; e.reg_data = 2'b10; e.reg_write = 1; add(e, 1'($urandom)); end
    end else begin
      e = '0; e.data_to_mem = 1; e.alusrca = 1; e.alusrcb = 2'b10; add(e, 1'($urandom));
      e = '0; e.mem_req = 1; e.lord = 1; e.mem_write = sb;
      mem_phase(e, wmem, 0);
      if (!sb) begin e = '0; e.reg_write = 1; e.reg_data = 2'b01; add(e, 1'($urandom)); end
    end
  endtask

  // Entered and left at posedge+1; stops early at negedge after entry 'upto'.
  task automatic play(input int upto);
    cyc_t t;
    int   i = 0;
    while (q.size() > 0) begin
      t = q.pop_front();
      mem_ready = t.rdy;
      @(negedge clk);
      chk($sformatf("%s_c%0d", cur_tag, i), obs(), t.e);
      if (i == upto) return;
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic set_inst(input logic [3:0] cc, input logic [2:0] opc, input bit lb, input bit ib,
                          input bit sb, input logic [2:0] f);
    inst = {cc, opc, lb, ib, 2'($urandom), sb, 20'($urandom)};
    func = f;
  endtask

  task automatic run(input string tag, input logic [3:0] cc, input logic [2:0] opc, input bit lb,
                     input bit ib, input bit sb, input logic [2:0] f, input int wif, input int wmem);
    cur_tag = tag;
    set_inst(cc, opc, lb, ib, sb, f);
    q.delete();
    gen(cc, opc, lb, ib, sb, f, wif, wmem);
    play(-1);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #1 chk({tag, "_async"}, obs(), '0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_idle"}, obs(), '0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] opc_tab [0:6];
    opc_tab = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd2, 3'd5, 3'd0};
    rst = 1'b0; mem_ready = 1'b0; inst = '0; func = '0; {z, c, n, v} = 4'b0000;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b1;
    @(negedge clk);
    chk("reset_outs", obs(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", obs(), '0);
    @(posedge clk); #1;

    run("add", 4'd14, 3'd0, 0, 0, 0, 3'd0, 0, 0);
    z = 1; run("cmp_eq_z1", 4'd0, 3'd0, 0, 0, 0, 3'd6, 0, 0);
    z = 0; run("cmp_eq_z0", 4'd0, 3'd0, 0, 0, 0, 3'd6, 0, 0);
    run("ldr_w3", 4'd14, 3'd2, 0, 1, 0, 3'd0, 1, 3);
    run("bl", 4'd14, 3'd5, 1, 0, 0, 3'd0, 0, 0);
    run("str_w2", 4'd14, 3'd2, 0, 1, 1, 3'd0, 2, 2);
    run("illegal", 4'd14, 3'd7, 0, 0, 0, 3'd0, 0, 0);
    run("nv", 4'd15, 3'd0, 0, 0, 0, 3'd0, 0, 0);
    run("orr_imm", 4'd14, 3'd0, 0, 1, 0, 3'd4, 0, 0);

`ifdef MC_CTRL_TIMEOUT_EN
    run("ready_on_16th", 4'd14, 3'd0, 0, 0, 0, 3'd0, 15, 0);
    begin
      outs_t e;
      cur_tag = "timeout";
      set_inst(4'd14, 3'd0, 0, 0, 0, 3'd0);
      q.delete();
      e = '0; e.mem_req = 1; e.alusrcb = 2'b01;
      for (int k = 0; k < 16; k++) add(e, 1'b0);
      e = '0; e.fault = 1;
      for (int k = 0; k < 4; k++) add(e, 1'($urandom));
      play(-1);
      reset_pulse("fault_clr");
    end
`else
    run("long_wait_if", 4'd14, 3'd0, 0, 0, 0, 3'd0, 20, 0);
    run("long_wait_ld", 4'd14, 3'd2, 0, 0, 0, 3'd0, 0, 20);
`endif

    cur_tag = "rst_ld";
    set_inst(4'd14, 3'd2, 0, 1, 0, 3'd0);
    q.delete();
    gen(4'd14, 3'd2, 0, 1, 0, 3'd0, 0, 5);
    play(3);
    #2 rst = 1'b0;
    #1 chk("rst_mid_ld_mem_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    #0 rst = 1'b0;
    reset_pulse("rst_ld");
    run("add_after_rst", 4'd14, 3'd0, 0, 0, 0, 3'd1, 0, 0);

    for (int t = 0; t < 200; t++) begin
      logic [3:0] cc;
      logic [2:0] opc;
      cc  = ($urandom_range(0, 1) == 0) ? 4'd14 : 4'($urandom);
      opc = (($urandom % 8) == 7) ? 3'($urandom) : opc_tab[$urandom_range(0, 6)];
      {z, c, n, v} = 4'($urandom);
      run($sformatf("rnd%0d", t), cc, opc, 1'($urandom), 1'($urandom), 1'($urandom),
          3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
